id_ex_stage: RTL and testbench

//  ID/EX pipeline register and operand-forwarding stage of the RV32I core.

---
 rtl/id_ex_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use bubble insertion.
// One cycle from ID inputs to EX outputs; hazard_stall is combinational and holds ID/IF upstream.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [2:0]         id_alu_control,
  input  logic               id_alu_src,
  input  logic               id_mem_read,
  input  logic               id_reg_write,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic               mem_reg_write,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]    mem_result,
  input  logic               wb_reg_write,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_result,
  output logic               hazard_stall,
  output logic               ex_valid,
  output logic [2:0]         alu_control,
  output logic [XLEN-1:0]    left_operand,
  output logic [XLEN-1:0]    right_operand,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read
);

  localparam logic [2:0] ALU_ADD = 3'b010;

  logic               r_valid;
  logic [2:0]         r_alu_control;
  logic               r_alu_src;
  logic               r_mem_read;
  logic               r_reg_write;
  logic [RADDR_W-1:0] r_rs1;
  logic [RADDR_W-1:0] r_rs2;
  logic [RADDR_W-1:0] r_rd;
  logic [XLEN-1:0]    r_rs1_data;
  logic [XLEN-1:0]    r_rs2_data;
  logic [XLEN-1:0]    r_imm;

  logic               w_hazard;
  logic [XLEN-1:0]    w_fwd_rs1;
  logic [XLEN-1:0]    w_fwd_rs2;

  // rs2 is checked even for immediate-form instructions; a spurious bubble is harmless.
  assign w_hazard = r_valid && r_mem_read && (r_rd != '0) && id_valid &&
                    ((r_rd == id_rs1) || (r_rd == id_rs2));

  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == r_rs1))
      w_fwd_rs1 = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == r_rs1))
      w_fwd_rs1 = wb_result;
  end

  always_comb begin
    w_fwd_rs2 = r_rs2_data;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == r_rs2))
      w_fwd_rs2 = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == r_rs2))
      w_fwd_rs2 = wb_result;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_alu_control <= ALU_ADD;
      r_alu_src     <= 1'b0;
      r_mem_read    <= 1'b0;
      r_reg_write   <= 1'b0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
      r_rs1_data    <= '0;
      r_rs2_data    <= '0;
      r_imm         <= '0;
    end else if (flush || (!stall && w_hazard)) begin
      r_valid       <= 1'b0;
      r_alu_control <= ALU_ADD;
      r_alu_src     <= 1'b0;
      r_mem_read    <= 1'b0;
      r_reg_write   <= 1'b0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
      r_rs1_data    <= '0;
      r_rs2_data    <= '0;
      r_imm         <= '0;
    end else if (stall) begin
      // Capture forwarded values so a write-back retiring during the hold is kept.
      r_rs1_data <= w_fwd_rs1;
      r_rs2_data <= w_fwd_rs2;
    end else begin
      r_valid       <= id_valid;
      r_alu_control <= id_alu_control;
      r_alu_src     <= id_alu_src;
      r_mem_read    <= id_mem_read && id_valid;
      r_reg_write   <= id_reg_write && id_valid;
      r_rs1         <= id_rs1;
      r_rs2         <= id_rs2;
      r_rd          <= id_rd;
      r_rs1_data    <= id_rs1_data;
      r_rs2_data    <= id_rs2_data;
      r_imm         <= id_imm;
    end
  end

  assign hazard_stall  = w_hazard;
  assign ex_valid      = r_valid;
  assign alu_control   = r_alu_control;
  assign left_operand  = w_fwd_rs1;
  assign right_operand = r_alu_src ? r_imm : w_fwd_rs2;
  assign ex_store_data = w_fwd_rs2;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: each cycle's expected EX outputs are queued by the stimulus
// and checked by an independent monitor on the falling edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic        id_valid, id_alu_src, id_mem_read, id_reg_write;
  logic [2:0]  id_alu_control;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        hazard_stall, ex_valid, ex_reg_write, ex_mem_read;
  logic [2:0]  alu_control;
  logic [31:0] left_operand, right_operand, ex_store_data;
  logic [4:0]  ex_rd;

  typedef struct packed {
    logic        hz;
    logic        vld;
    logic [2:0]  alu;
    logic [31:0] left;
    logic [31:0] right;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .alu_control(alu_control),
    .left_operand(left_operand), .right_operand(right_operand),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  // Monitor: outputs are presented every cycle, so one queued expectation is consumed per falling edge.
  always @(negedge clk) begin
    exp_t e, g;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{hz: hazard_stall, vld: ex_valid, alu: alu_control, left: left_operand,
            right: right_operand, store: ex_store_data, rd: ex_rd,
            rw: ex_reg_write, mr: ex_mem_read};
      n_cmp++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL cycle%0d: got hz=%b vld=%b alu=%b l=%h r=%h st=%h rd=%0d rw=%b mr=%b | want hz=%b vld=%b alu=%b l=%h r=%h st=%h rd=%0d rw=%b mr=%b",
                 cyc, g.hz, g.vld, g.alu, g.left, g.right, g.store, g.rd, g.rw, g.mr,
                 e.hz, e.vld, e.alu, e.left, e.right, e.store, e.rd, e.rw, e.mr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input logic hz, input logic vld, input logic [2:0] alu,
                          input logic [31:0] l, input logic [31:0] r, input logic [31:0] s,
                          input logic [4:0] rd, input logic rw, input logic mr);
    exp_t e;
    e = '{hz: hz, vld: vld, alu: alu, left: l, right: r, store: s, rd: rd, rw: rw, mr: mr};
    exp_q.push_back(e);
  endtask

  task automatic expect_bubble();
    expect_o(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic set_id(input logic v, input logic [2:0] alu, input logic src, input logic mr,
                        input logic rw, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm);
    id_valid = v; id_alu_control = alu; id_alu_src = src; id_mem_read = mr; id_reg_write = rw;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
  endtask

  task automatic set_id_idle();
    set_id(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic set_fwd(input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
                         input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
    mem_reg_write = mrw; mem_rd = mrd; mem_result = mres;
    wb_reg_write = wrw; wb_rd = wrd; wb_result = wres;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    // A valid instruction during reset must not be captured.
    set_id(1'b1, 3'b001, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd9, 32'h11, 32'h22, 32'h33);

    tick(); expect_bubble();
    tick(); reset = 1'b0; set_id_idle(); expect_bubble();
    tick(); expect_bubble();

    // MEM beats WB on rs1
    tick(); set_id(1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 5'd3, 5'd6, 5'd5, 32'h111, 32'h222, 32'h0);
    expect_bubble();
    tick(); set_id_idle(); set_fwd(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB);
    expect_o(1'b0, 1'b1, 3'b010, 32'hA, 32'h222, 32'h222, 5'd5, 1'b1, 1'b0);

    // x0 is never forwarded; immediate selects right operand
    tick(); set_id(1'b1, 3'b001, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h7F);
    set_fwd(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0);
    expect_bubble();
    tick(); set_id_idle(); set_fwd(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE);
    expect_o(1'b0, 1'b1, 3'b001, 32'h0, 32'h7F, 32'h0, 5'd8, 1'b1, 1'b0);

    // WB feeds rs1 while MEM feeds rs2
    tick(); set_id(1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 5'd10, 5'd11, 5'd12, 32'h100, 32'h200, 32'h0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_bubble();
    tick(); set_id_idle(); set_fwd(1'b1, 5'd11, 32'h33, 1'b1, 5'd10, 32'h44);
    expect_o(1'b0, 1'b1, 3'b110, 32'h44, 32'h33, 32'h33, 5'd12, 1'b1, 1'b0);

    // Load-use on rs2 -> hazard, then bubble, then dependent instruction
    tick(); set_id(1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 5'd2, 5'd0, 5'd7, 32'h1000, 32'h0, 32'h8);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_bubble();
    tick(); set_id(1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 5'd1, 5'd7, 5'd9, 32'h5, 32'h6, 32'h0);
    expect_o(1'b1, 1'b1, 3'b010, 32'h1000, 32'h8, 32'h0, 5'd7, 1'b1, 1'b1);
    tick(); expect_bubble();
    tick(); set_id_idle();
    expect_o(1'b0, 1'b1, 3'b010, 32'h5, 32'h6, 32'h6, 5'd9, 1'b1, 1'b0);

    // External stall keeps a write-back that retires during the hold
    tick(); set_id(1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 5'd4, 5'd13, 5'd14, 32'h10, 32'h20, 32'h0);
    expect_bubble();
    tick(); stall = 1'b1; set_id_idle(); set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h55);
    expect_o(1'b0, 1'b1, 3'b000, 32'h55, 32'h20, 32'h20, 5'd14, 1'b1, 1'b0);
    tick(); set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    expect_o(1'b0, 1'b1, 3'b000, 32'h55, 32'h20, 32'h20, 5'd14, 1'b1, 1'b0);
    tick(); stall = 1'b0;
    set_id(1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd15, 32'h0, 32'h0, 32'h20);
    expect_o(1'b0, 1'b1, 3'b000, 32'h55, 32'h20, 32'h20, 5'd14, 1'b1, 1'b0);

    // Flush beats stall and hazard
    tick(); stall = 1'b1; flush = 1'b1;
    set_id(1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 5'd15, 5'd1, 5'd16, 32'h77, 32'h0, 32'h0);
    expect_o(1'b1, 1'b1, 3'b010, 32'h0, 32'h20, 32'h0, 5'd15, 1'b1, 1'b1);
    tick(); stall = 1'b0; flush = 1'b0;
    set_id(1'b1, 3'b010, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd17, 32'h0, 32'h0, 32'h4);
    expect_bubble();

    // Stall beats hazard: load is held, then bubbled once stall drops
    tick(); stall = 1'b1;
    set_id(1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 5'd17, 5'd0, 5'd18, 32'h9, 32'h0, 32'h0);
    expect_o(1'b1, 1'b1, 3'b010, 32'h0, 32'h4, 32'h0, 5'd17, 1'b1, 1'b1);
    tick(); stall = 1'b0;
    expect_o(1'b1, 1'b1, 3'b010, 32'h0, 32'h4, 32'h0, 5'd17, 1'b1, 1'b1);
    tick(); set_id_idle(); expect_bubble();
    tick(); expect_bubble();

    // Asynchronous reset mid-stream, asserted and released off the clock edge
    tick(); set_id(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 5'd20, 5'd21, 5'd22, 32'h3, 32'h4, 32'h0);
    expect_bubble();
    tick(); set_id_idle();
    expect_o(1'b0, 1'b1, 3'b001, 32'h3, 32'h4, 32'h4, 5'd22, 1'b1, 1'b0);
    tick(); set_id(1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 5'd24, 5'd25, 5'd23, 32'h9, 32'hA, 32'h0);
    expect_bubble();
    #1 reset = 1'b1;
    tick(); #1 reset = 1'b0; expect_bubble();
    tick(); set_id(1'b1, 3'b111, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h5);
    expect_o(1'b0, 1'b1, 3'b110, 32'h9, 32'hA, 32'hA, 5'd23, 1'b1, 1'b0);

    // Undefined ALU code passes through; invalid ID gates reg_write/mem_read
    tick(); set_id(1'b0, 3'b010, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    expect_o(1'b0, 1'b1, 3'b111, 32'h0, 32'h5, 32'h0, 5'd1, 1'b0, 1'b0);
    tick(); set_id_idle(); expect_bubble();

    tick();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
